// File: rtl/hex_ascii_serializer.sv
// hex_ascii_serializer: streams a word as ASCII hex digits, MS nibble first.
// Define HEX_PREFIX_EN to emit a "0x" prefix ahead of every word.
module hex_ascii_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LOWER,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [7:0]        OUT_CHAR,
  output logic              OUT_LAST
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_w
    $error("DATA_W must be a multiple of 4 and >= 4");
  end

`ifdef HEX_PREFIX_EN
  typedef enum logic [1:0] {IDLE, PREFIX0, PREFIX1, DIGITS} state_t;
`else
  typedef enum logic {IDLE, DIGITS} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              lower_q, lower_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        nib;
  logic [7:0]        digit;
  logic              last;

  // Word is shifted left so the digit on show is always the top nibble
  assign nib   = data_q[DATA_W-1 -: 4];
  assign digit = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
               : ((lower_q ? 8'h57 : 8'h37) + {4'h0, nib});
  assign last  = (cnt_q == LAST_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      lower_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lower_q <= lower_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    lower_d   = lower_q;
    cnt_d     = cnt_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    OUT_CHAR  = 8'h00;
    OUT_LAST  = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          data_d  = IN_DATA;
          lower_d = IN_LOWER;
          cnt_d   = '0;
`ifdef HEX_PREFIX_EN
          state_d = PREFIX0;
`else
          state_d = DIGITS;
`endif
        end
      end
`ifdef HEX_PREFIX_EN
      PREFIX0: begin
        OUT_VALID = 1'b1;
        OUT_CHAR  = 8'h30;
        if (OUT_READY) state_d = PREFIX1;
      end
      PREFIX1: begin
        OUT_VALID = 1'b1;
        OUT_CHAR  = 8'h78;
        if (OUT_READY) state_d = DIGITS;
      end
`endif
      DIGITS: begin
        OUT_VALID = 1'b1;
        OUT_CHAR  = digit;
        OUT_LAST  = last;
        if (OUT_READY) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            data_d = data_q << 4;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// tb_hex_ascii_serializer: directed and random words against a string model.
// Model tracks HEX_PREFIX_EN the same way as the design.
module tb_hex_ascii_serializer;

  localparam int DW  = 32;
  localparam int NIB = DW / 4;

  logic          CLK;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic          IN_LOWER;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [7:0]    OUT_CHAR;
  logic          OUT_LAST;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  string hexu = "0123456789ABCDEF";
  string hexl = "0123456789abcdef";

  hex_ascii_serializer #(.DATA_W(DW)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .IN_DATA(IN_DATA),
    .IN_LOWER(IN_LOWER),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_CHAR(OUT_CHAR),
    .OUT_LAST(OUT_LAST)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected character string of one word
  task automatic build_exp(input logic [DW-1:0] w, input logic lw);
    int d;
    exp_q.delete();
`ifdef HEX_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int i = NIB - 1; i >= 0; i--) begin
      d = int'((w >> (4 * i)) & 'hF);
      exp_q.push_back(lw ? hexl[d] : hexu[d]);
    end
  endtask

  task automatic accept(input logic [DW-1:0] w, input logic lw);
    int n;
    n = 0;
    while (IN_READY !== 1'b1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("accept_wait", IN_READY, 1);
    IN_VALID = 1'b1;
    IN_DATA  = w;
    IN_LOWER = lw;
    build_exp(w, lw);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_DATA  = $urandom;
    IN_LOWER = ~lw;
  endtask

  // Expects the first char of exp_q to be on the outputs right now
  task automatic stream(input int stall_at, input int stall_n, input bit rnd);
    int s;
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      s = (i == stall_at) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      check("valid", OUT_VALID, 1);
      check("busy", IN_READY, 0);
      check("char", OUT_CHAR, exp_q[i]);
      check("last", OUT_LAST, (i == n - 1) ? 1 : 0);
      OUT_READY = 1'b0;
      repeat (s) begin
        @(posedge CLK); #1;
        check("hold_valid", OUT_VALID, 1);
        check("hold_char", OUT_CHAR, exp_q[i]);
        check("hold_last", OUT_LAST, (i == n - 1) ? 1 : 0);
      end
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b0;
    check("gap_valid", OUT_VALID, 0);
    check("gap_ready", IN_READY, 1);
  endtask

  initial begin
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_LOWER  = 1'b0;
    OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", OUT_VALID, 0);
    check("rst_char", OUT_CHAR, 0);
    check("rst_last", OUT_LAST, 0);
    check("rst_ready", IN_READY, 1);

    // Reset wins over an offered word
    IN_VALID = 1'b1;
    IN_DATA  = 32'h12345678;
    @(posedge CLK); #1;
    check("rst_prio_valid", OUT_VALID, 0);
    check("rst_prio_ready", IN_READY, 1);
    IN_VALID = 1'b0;
    RST      = 1'b0;
    @(posedge CLK); #1;

    accept(32'hDEADBEEF, 1'b0);
    stream(-1, 0, 1'b0);

    accept(32'h00C0FFEE, 1'b1);
    stream(-1, 0, 1'b0);

    // Third digit held for three stalled cycles
`ifdef HEX_PREFIX_EN
    accept(32'hDEADBEEF, 1'b0);
    stream(4, 3, 1'b0);
`else
    accept(32'hDEADBEEF, 1'b0);
    stream(2, 3, 1'b0);
`endif

    accept(32'h1234ABCD, 1'b1);
    stream(-1, 0, 1'b0);

    // Reset after two characters discards the word
    accept(32'h9ABCDEF0, 1'b0);
    OUT_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("pre_rst_char", OUT_CHAR, exp_q[i]);
      @(posedge CLK); #1;
    end
    RST      = 1'b1;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_ready", IN_READY, 1);
    check("mid_rst_char", OUT_CHAR, 0);
    RST       = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    accept(32'h0000000F, 1'b0);
    stream(-1, 0, 1'b0);

    // IN_VALID held high across two words
    IN_VALID  = 1'b1;
    IN_DATA   = 32'hA5A5F00D;
    IN_LOWER  = 1'b0;
    build_exp(32'hA5A5F00D, 1'b0);
    @(posedge CLK); #1;
    IN_DATA = 32'h13579BDF;
    stream(-1, 0, 1'b0);
    build_exp(32'h13579BDF, 1'b0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    stream(-1, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      accept(DW'($urandom), 1'($urandom_range(0, 1)));
      stream(-1, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
